// File: rtl/int_mul_pipe.sv
// int_mul_pipe: pipelined unsigned integer multiplier, P = A * B (full 2*DATA_SIZE-bit product).
// B is consumed one CHUNK-bit digit per stage; stage k adds A * digit_k << k*CHUNK to the
// running accumulator, so the product is complete after S = DATA_SIZE/CHUNK stages.
// A valid bit and a sideband tag travel with each item.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, overrides en
//   en         global pipeline enable; 0 freezes every register
//   in_valid   A/B/tag_in carry a new operand pair
//   A, B       unsigned operands (DATA_SIZE bits)
//   tag_in     sideband tag (TAG_W bits)
//   out_valid  P/tag_out carry a new product
//   P          product A*B (2*DATA_SIZE bits), held through bubbles
//   tag_out    tag belonging to P
//
// Optional feature: define INTMUL_IN_REG_EN to add an operand register ahead of stage 0
// (latency S+1 instead of S).

module int_mul_pipe #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned CHUNK     = 8,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [DATA_SIZE-1:0]   A,
    input  logic [DATA_SIZE-1:0]   B,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   out_valid,
    output logic [2*DATA_SIZE-1:0] P,
    output logic [TAG_W-1:0]       tag_out
);

    localparam int unsigned S  = DATA_SIZE / CHUNK;
    localparam int unsigned PW = 2 * DATA_SIZE;

    // Operands feeding stage 0.
    logic                 src_valid;
    logic [DATA_SIZE-1:0] src_a;
    logic [DATA_SIZE-1:0] src_b;
    logic [TAG_W-1:0]     src_tag;

`ifdef INTMUL_IN_REG_EN
    logic                 in_valid_q;
    logic [DATA_SIZE-1:0] in_a_q;
    logic [DATA_SIZE-1:0] in_b_q;
    logic [TAG_W-1:0]     in_tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_a_q     <= '0;
            in_b_q     <= '0;
            in_tag_q   <= '0;
        end else if (en) begin
            in_valid_q <= in_valid;
            if (in_valid) begin
                in_a_q   <= A;
                in_b_q   <= B;
                in_tag_q <= tag_in;
            end
        end
    end

    assign src_valid = in_valid_q;
    assign src_a     = in_a_q;
    assign src_b     = in_b_q;
    assign src_tag   = in_tag_q;
`else
    assign src_valid = in_valid;
    assign src_a     = A;
    assign src_b     = B;
    assign src_tag   = tag_in;
`endif

    // Per-stage state. b_q[k] holds the digits of B not yet consumed, right-aligned, so the
    // next stage always takes its digit from the low CHUNK bits. The last stage needs no
    // operands, only the finished accumulator and tag.
    logic [S-1:0]         valid_q;
    logic [PW-1:0]        acc_q [S];
    logic [TAG_W-1:0]     tag_q [S];
    logic [DATA_SIZE-1:0] a_q   [S];
    logic [DATA_SIZE-1:0] b_q   [S];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < S; k++) begin
                acc_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= src_valid;
            for (int k = 1; k < S; k++) begin
                valid_q[k] <= valid_q[k-1];
            end

            if (src_valid) begin
                acc_q[0] <= PW'(src_a) * PW'(src_b[CHUNK-1:0]);
                tag_q[0] <= src_tag;
                if (S > 1) begin
                    a_q[0] <= src_a;
                    b_q[0] <= src_b >> CHUNK;
                end
            end

            // Data registers load only behind a valid item; bubbles leave them holding.
            for (int k = 1; k < S; k++) begin
                if (valid_q[k-1]) begin
                    acc_q[k] <= acc_q[k-1]
                              + ((PW'(a_q[k-1]) * PW'(b_q[k-1][CHUNK-1:0])) << (k * CHUNK));
                    tag_q[k] <= tag_q[k-1];
                    if (k < S - 1) begin
                        a_q[k] <= a_q[k-1];
                        b_q[k] <= b_q[k-1] >> CHUNK;
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[S-1];
    assign P         = acc_q[S-1];
    assign tag_out   = tag_q[S-1];

endmodule

// File: tb/tb_int_mul_pipe.sv
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module tb_int_mul_pipe;

    localparam int unsigned W     = `DATA_SIZE_ARB;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned PW    = 2 * W;
    localparam int          S     = W / CHUNK;
`ifdef INTMUL_IN_REG_EN
    localparam int          LAT   = S + 1;
`else
    localparam int          LAT   = S;
`endif

    logic             clk;
    logic             reset;
    logic             en;
    logic             in_valid;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic [PW-1:0]    P;
    logic [TAG_W-1:0] tag_out;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    int_mul_pipe #(
        .DATA_SIZE (W),
        .CHUNK     (CHUNK),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .P         (P),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every accepted item is scheduled to emerge after LAT enabled edges.
    typedef struct {
        logic [PW-1:0]    p;
        logic [TAG_W-1:0] tag;
        longint           due;
    } item_t;

    item_t            mq[$];
    longint           en_cnt  = 0;
    logic             m_valid = 1'b0;
    logic [PW-1:0]    m_p     = '0;
    logic [TAG_W-1:0] m_tag   = '0;

    always @(posedge clk) begin
        item_t it;
        if (reset) begin
            mq.delete();
            m_valid = 1'b0;
            m_p     = '0;
            m_tag   = '0;
        end else if (en) begin
            en_cnt++;
            if (in_valid) begin
                it.p   = PW'(A) * PW'(B);
                it.tag = tag_in;
                it.due = en_cnt + LAT - 1;
                mq.push_back(it);
            end
            m_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due == en_cnt) begin
                m_valid = 1'b1;
                m_p     = mq[0].p;
                m_tag   = mq[0].tag;
                void'(mq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
            end
            n_cmp++;
            if (P !== m_p) begin
                n_fail++;
                $display("FAIL model_P t=%0t got=%h exp=%h", $time, P, m_p);
            end
            n_cmp++;
            if (tag_out !== m_tag) begin
                n_fail++;
                $display("FAIL model_tag t=%0t got=%h exp=%h", $time, tag_out, m_tag);
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        A        = a;
        B        = b;
        tag_in   = t;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        drive(1'b1, W'($urandom), W'($urandom), TAG_W'($urandom));
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (P !== '0) begin n_fail++; $display("FAIL reset_P got=%h exp=0", P); end
        n_cmp++;
        if (tag_out !== '0) begin n_fail++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
        drive(1'b0, '0, '0, '0);
        reset = 1'b0;
    endtask

    task automatic test_corner();
        logic [W-1:0]  ones;
        logic [PW-1:0] exp1;
        ones = '1;
        exp1 = PW'(ones) * PW'(ones);
        @(negedge clk);
        drive(1'b1, ones, ones, 8'h5A);
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b1, '0, W'(32'h12345678), 8'hA5);
            else drive(1'b0, '0, '0, '0);
            if (i == LAT - 1) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL corner_early got=%b exp=0", out_valid); end
            end
            if (i == LAT) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL corner_valid got=%b exp=1", out_valid); end
                n_cmp++;
                if (P !== exp1) begin n_fail++; $display("FAIL corner_P got=%h exp=%h", P, exp1); end
                n_cmp++;
                if (tag_out !== 8'h5A) begin n_fail++; $display("FAIL corner_tag got=%h exp=5a", tag_out); end
            end
            if (i == LAT + 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== '0 || tag_out !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL corner_zero got=%b/%h/%h exp=1/0/a5", out_valid, P, tag_out);
                end
            end
            if (i == LAT + 2) begin
                n_cmp++;
                if (out_valid !== 1'b0 || P !== '0) begin
                    n_fail++;
                    $display("FAIL corner_hold got=%b/%h exp=0/0", out_valid, P);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_p [8];
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        for (int j = 0; j < 8; j++) begin
            a        = W'(j + 1);
            b        = W'(32'h01000001 * (j + 1));
            exp_p[j] = PW'(a) * PW'(b);
        end
        @(negedge clk);
        drive(1'b1, W'(1), W'(32'h01000001), 8'h10);
        for (int i = 1; i <= LAT + 8; i++) begin
            @(negedge clk);
            if (i < 8) drive(1'b1, W'(i + 1), W'(32'h01000001 * (i + 1)), TAG_W'(8'h10 + i));
            else drive(1'b0, '0, '0, '0);
            if (i >= LAT && i < LAT + 8) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== exp_p[i-LAT] || tag_out !== TAG_W'(8'h10 + i - LAT)) begin
                    n_fail++;
                    $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i - LAT, out_valid, P,
                             tag_out, exp_p[i-LAT], TAG_W'(8'h10 + i - LAT));
                end
            end
            if (i == LAT + 8) begin
                n_cmp++;
                if (out_valid !== 1'b0 || P !== exp_p[7]) begin
                    n_fail++;
                    $display("FAIL stream_end got=%b/%h exp=0/%h", out_valid, P, exp_p[7]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic [W-1:0]  a0, b0, a3, b3;
        logic [PW-1:0] p0, p3;
        a0 = W'($urandom);
        b0 = W'($urandom);
        a3 = W'($urandom);
        b3 = W'($urandom);
        p0 = PW'(a0) * PW'(b0);
        p3 = PW'(a3) * PW'(b3);
        @(negedge clk);
        drive(1'b1, a0, b0, 8'h21);
        for (int i = 1; i <= LAT + 4; i++) begin
            @(negedge clk);
            if (i == 3) drive(1'b1, a3, b3, 8'h24);
            else drive(1'b0, W'($urandom), W'($urandom), TAG_W'($urandom));
            if (i == LAT) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== p0) begin
                    n_fail++;
                    $display("FAIL bubble_first got=%b/%h exp=1/%h", out_valid, P, p0);
                end
            end
            if (i == LAT + 1 || i == LAT + 2) begin
                n_cmp++;
                if (out_valid !== 1'b0 || P !== p0 || tag_out !== 8'h21) begin
                    n_fail++;
                    $display("FAIL bubble_idle got=%b/%h/%h exp=0/%h/21", out_valid, P, tag_out, p0);
                end
            end
            if (i == LAT + 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== p3 || tag_out !== 8'h24) begin
                    n_fail++;
                    $display("FAIL bubble_second got=%b/%h/%h exp=1/%h/24", out_valid, P, tag_out, p3);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0]  a [3];
        logic [W-1:0]  b [3];
        logic [PW-1:0] p [3];
        for (int j = 0; j < 3; j++) begin
            a[j] = W'($urandom);
            b[j] = W'($urandom);
            p[j] = PW'(a[j]) * PW'(b[j]);
        end
        @(negedge clk);
        drive(1'b1, a[0], b[0], 8'h30);
        for (int i = 1; i <= LAT + 6; i++) begin
            @(negedge clk);
            // The third item is held on the inputs through the stall and accepted once.
            if (i == 1) drive(1'b1, a[1], b[1], 8'h31);
            else if (i <= 5) drive(1'b1, a[2], b[2], 8'h32);
            else drive(1'b0, '0, '0, '0);
            en = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            if (i >= LAT && i <= LAT + 2) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_frozen_%0d got=%b exp=0", i, out_valid); end
            end
            if (i >= LAT + 3 && i <= LAT + 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== p[i-LAT-3] || tag_out !== TAG_W'(8'h30 + i - LAT - 3)) begin
                    n_fail++;
                    $display("FAIL stall_item_%0d got=%b/%h/%h exp=1/%h", i - LAT - 3, out_valid, P,
                             tag_out, p[i-LAT-3]);
                end
            end
            if (i == LAT + 6) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup got=%b exp=0", out_valid); end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0]  an, bn;
        logic [PW-1:0] pn;
        an = W'($urandom);
        bn = W'($urandom);
        pn = PW'(an) * PW'(bn);
        @(negedge clk);
        drive(1'b1, W'($urandom), W'($urandom), 8'h40);
        for (int i = 1; i <= LAT + 5; i++) begin
            @(negedge clk);
            reset = 1'b0;
            en    = 1'b1;
            if (i < 3) drive(1'b1, W'($urandom), W'($urandom), TAG_W'(8'h40 + i));
            else if (i == 3) begin
                // Reset with en low: reset must still win.
                drive(1'b0, '0, '0, '0);
                reset = 1'b1;
                en    = 1'b0;
            end else if (i == 4) drive(1'b1, an, bn, 8'h4F);
            else drive(1'b0, '0, '0, '0);
            if (i >= 4 && i < 4 + LAT) begin
                n_cmp++;
                if (out_valid !== 1'b0 || P !== '0 || tag_out !== '0) begin
                    n_fail++;
                    $display("FAIL rst_flush_%0d got=%b/%h/%h exp=0/0/0", i, out_valid, P, tag_out);
                end
            end
            if (i == 4 + LAT) begin
                n_cmp++;
                if (out_valid !== 1'b1 || P !== pn || tag_out !== 8'h4F) begin
                    n_fail++;
                    $display("FAIL rst_new got=%b/%h/%h exp=1/%h/4f", out_valid, P, tag_out, pn);
                end
            end
        end
    endtask

    task automatic test_random();
        int seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
            en    = ($urandom_range(7) != 0);
            reset = ($urandom_range(99) == 0);
            drive($urandom_range(9) < 6, W'($urandom), W'($urandom), TAG_W'($urandom));
            if ($urandom_range(7) == 0) A = '1;
            if ($urandom_range(7) == 0) B = '1;
        end
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        n_cmp++;
        if (seen == 0) begin n_fail++; $display("FAIL random_outputs got=%0d exp=>0", seen); end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        drive(1'b0, '0, '0, '0);
        test_reset();
        test_corner();
        test_back_to_back();
        test_bubbles();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
